// File: rtl/pdm_array.sv
// pdm_array: multi-channel pulse-density modulator with double-buffered
// levels, per-channel enable/invert, a shared update prescaler and
// staggered accumulator start phases.
module pdm_array #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DIV      = 1,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_chan,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [CHANNELS-1:0] en_mask,
    input  logic [CHANNELS-1:0] inv_mask,
    input  logic                commit,
    output logic                commit_pending,
    output logic [CHANNELS-1:0] pdm_out
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Start phase of channel c, spread evenly around the accumulator circle.
    function automatic logic [WIDTH-1:0] seed_of(input int c);
        int s;
        s = (c * (1 << WIDTH)) / CHANNELS;
        return s[WIDTH-1:0];
    endfunction

    logic [PW-1:0]       p_q, p_d;
    state_t              state_q, state_d;
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    active_d [CHANNELS];
    logic [WIDTH-1:0]    acc_q    [CHANNELS];
    logic [WIDTH-1:0]    acc_d    [CHANNELS];
    logic [CHANNELS-1:0] en_q, en_d;
    logic [CHANNELS-1:0] inv_q, inv_d;
    logic [CHANNELS-1:0] pdm_out_q, pdm_out_d;
    logic                tick;
    logic                transfer;

    assign tick           = (p_q == P_LAST);
    assign transfer       = (state_q == PENDING) && tick;
    assign commit_pending = (state_q == PENDING);
    assign pdm_out        = pdm_out_q;

    // Prescaler count and commit handshake; a commit seen while PENDING
    // or on the transfer edge itself is dropped.
    always_comb begin
        p_d     = tick ? '0 : p_q + PW'(1);
        state_d = state_q;
        case (state_q)
            IDLE:    if (commit) state_d = PENDING;
            PENDING: if (tick)   state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Shadow writes and the atomic shadow-to-active transfer; the transfer
    // copies pre-edge shadow values, so a same-cycle write waits for the
    // next commit.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        en_d     = en_q;
        inv_d    = inv_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_en && (int'(wr_chan) == c)) shadow_d[c] = wr_data;
        end
        if (transfer) begin
            active_d = shadow_q;
            en_d     = en_mask;
            inv_d    = inv_mask;
        end
    end

    // Accumulate on ticks; the carry is the density bit. Disabled channels
    // park at their seed so re-enabling restarts the pattern from it.
    always_comb begin
        logic [WIDTH:0] sum;
        acc_d     = acc_q;
        pdm_out_d = pdm_out_q;
        sum       = '0;
        if (tick) begin
            for (int c = 0; c < CHANNELS; c++) begin
                sum = {1'b0, active_q[c]} + {1'b0, acc_q[c]};
                if (en_q[c]) begin
                    acc_d[c]     = sum[WIDTH-1:0];
                    pdm_out_d[c] = sum[WIDTH] ^ inv_q[c];
                end else begin
                    acc_d[c]     = seed_of(c);
                    pdm_out_d[c] = 1'b0;
                end
            end
        end
    end

    // All state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q       <= '0;
            state_q   <= IDLE;
            en_q      <= '0;
            inv_q     <= '0;
            pdm_out_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= '0;
                active_q[c] <= '0;
                acc_q[c]    <= seed_of(c);
            end
        end else begin
            p_q       <= p_d;
            state_q   <= state_d;
            en_q      <= en_d;
            inv_q     <= inv_d;
            pdm_out_q <= pdm_out_d;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= shadow_d[c];
                active_q[c] <= active_d[c];
                acc_q[c]    <= acc_d[c];
            end
        end
    end

endmodule
